fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage of the 5-stage RISC-V pipeline.
- Holds the PC and the IF/ID pipeline register.
- Drives the instruction-memory address.
- Consumes the PCWrite / IFIDWrite stall controls from the hazard detection unit and the branch redirect from EX.
- Produces the IF/ID instruction that the hazard detection unit and the decoder read.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
IMEM_WORDS, 256, instruction memory size in 32-bit words; fetches at or beyond this are faults
NOP_INSTR, 32'h0000_0013, encoding (addi x0,x0,0) injected on flush/fault/reset

Ports:
clk  in  1  pipeline clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
PCWrite  in  1  1 = PC may update; 0 = PC holds (stall)
IFIDWrite  in  1  1 = IF/ID register may load; 0 = holds (stall)
branch_taken  in  1  EX-stage redirect request; flushes IF/ID
branch_target  in  32  redirect PC from EX
imem_rdata  in  32  combinational instruction-memory read data for imem_addr
imem_addr  out  32  byte address to instruction memory; equals pc
pc  out  32  current fetch PC
IFID_pc  out  32  PC of instruction held in IF/ID
IFID_instruction  out  32  instruction held in IF/ID
IFID_valid  out  1  1 = IF/ID holds a real fetched instruction
fetch_fault  out  1  sticky flag: a fetch beyond IMEM_WORDS occurred

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous and active-high; it has priority over all other inputs.
  - Reset values: pc=RESET_PC, IFID_pc=0, IFID_instruction=NOP_INSTR, IFID_valid=0, fetch_fault=0.
- imem_addr = pc, combinational. imem_rdata is sampled the same cycle (zero-wait memory).
- Word index = pc[31:2]. Out of range when word index >= IMEM_WORDS.
- Per-edge priority, highest first:
  1. rst: reset values as above.
  2. branch_taken=1 (overrides stalls):
     - pc <= {branch_target[31:2],2'b00}; low bits are forced to zero.
     - IFID_instruction <= NOP_INSTR, IFID_valid <= 0, IFID_pc <= 0.
  3. Otherwise PC and IF/ID update independently:
     - PCWrite=1: pc <= pc+4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0). PCWrite=0: pc holds.
     - IFIDWrite=1 and in range: IFID_instruction <= imem_rdata, IFID_pc <= pc, IFID_valid <= 1.
     - IFIDWrite=1 and out of range: IFID_instruction <= NOP_INSTR, IFID_pc <= pc, IFID_valid <= 0, fetch_fault <= 1.
     - IFIDWrite=0: all IF/ID fields hold.
- fetch_fault is sticky until rst. It never blocks PC advance.
- PCWrite=1 with IFIDWrite=0 is legal and behaves literally: the instruction at the old pc is skipped. The hazard unit never issues this combination.
- Latency: an instruction at address A appears on IFID_instruction one edge after pc==A with IFIDWrite=1.
- First cycle after reset: IFID_valid=0, and pc=RESET_PC is fetched on that edge.
- A stall held for N cycles freezes pc and IF/ID for exactly N edges. Release resumes at the frozen pc with no instruction lost or duplicated.
- If rst is asserted mid-stall or mid-redirect, reset wins and the pending redirect is discarded.

Optional Feature:
STALL_CNT_EN
- Defined:
  - Adds output stall_cycles (32 bits, reset 0).
  - Increments on each non-reset edge where PCWrite=0 and branch_taken=0.
  - Saturates at 32'hFFFF_FFFF.
  - Adds output flush_count (16 bits, reset 0), incremented on each branch_taken edge and saturating.
- Undefined: neither port exists, and the remaining logic is identical.

Test Plan:
- Reset, then 4 edges with PCWrite=IFIDWrite=1 and imem returning {pc}: pc 0->4->8->C->10; IFID_pc 0,4,8,C with matching instructions; IFID_valid=0 only on the first post-reset cycle.
- At pc=8, hold PCWrite=IFIDWrite=0 for 2 edges, then release: pc stays 8 and IFID holds instr@4 for 2 edges, then instr@8 appears; no skip or duplicate.
- At pc=10, branch_taken=1 with target 32'h0000_0042 while PCWrite=0: next pc=0x40, IFID_instruction=0x00000013, IFID_valid=0; next edge IFID_pc=0x40.
- IMEM_WORDS=4, run from 0: fetch at pc=0x10 gives IFID NOP with valid=0 and fetch_fault=1; fault stays 1 after branching back to 0 and clears only on rst.
- RESET_PC=32'hFFFF_FFFC, advance 1 edge: pc=0 (wrap). Assert rst in the same cycle as branch_taken: pc=RESET_PC.
- With STALL_CNT_EN: 3 stall edges plus 1 branch edge gives stall_cycles=3 and flush_count=1. A build without the macro compiles with neither port present.

Source files
------------

// File: rtl/fetch_stage.sv
// ============================================================================
// fetch_stage
// ----------------------------------------------------------------------------
// Instruction-fetch stage of the 5-stage RISC-V pipeline. Holds the fetch PC
// and the IF/ID pipeline register, drives the instruction-memory address and
// samples the zero-wait instruction memory in the same cycle.
//
// Optional feature macro: STALL_CNT_EN
//    When defined, adds the stall_cycles and flush_count statistic outputs.
//    When undefined, neither port exists and all other logic is unchanged.
//
// Parameters:
//    RESET_PC    PC value loaded on reset
//    IMEM_WORDS  instruction memory size in 32-bit words; fetches at or
//                beyond this word index are faults
//    NOP_INSTR   encoding injected into IF/ID on reset/flush/fault
//
// Ports:
//    clk               pipeline clock, all state updates on rising edge
//    rst               synchronous active-high reset, highest priority
//    PCWrite           1 = PC may advance, 0 = PC holds (stall)
//    IFIDWrite         1 = IF/ID may load, 0 = IF/ID holds (stall)
//    branch_taken      EX-stage redirect, overrides stalls, flushes IF/ID
//    branch_target     redirect PC from EX (low two bits ignored)
//    imem_rdata        combinational instruction-memory read data
//    imem_addr         byte address to instruction memory (equals pc)
//    pc                current fetch PC
//    IFID_pc           PC of the instruction held in IF/ID
//    IFID_instruction  instruction held in IF/ID
//    IFID_valid        1 = IF/ID holds a real fetched instruction
//    fetch_fault       sticky flag, set by an out-of-range fetch
//    stall_cycles      (STALL_CNT_EN) saturating count of PC stall edges
//    flush_count       (STALL_CNT_EN) saturating count of redirect edges
// ============================================================================
module fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_WORDS = 256,
   parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        PCWrite,
   input  logic        IFIDWrite,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic [31:0] imem_rdata,
   output logic [31:0] imem_addr,
   output logic [31:0] pc,
   output logic [31:0] IFID_pc,
   output logic [31:0] IFID_instruction,
   output logic        IFID_valid,
   output logic        fetch_fault
`ifdef STALL_CNT_EN
   ,
   output logic [31:0] stall_cycles,
   output logic [15:0] flush_count
`endif
);

   // Memory size widened once so the range test is a plain 32-bit compare.
   localparam logic [31:0] IMEM_WORDS_W = 32'(IMEM_WORDS);

   logic [31:0] r_pc;
   logic [31:0] r_ifidPc;
   logic [31:0] r_ifidInstr;
   logic        r_ifidValid;
   logic        r_fetchFault;

   logic [31:0] w_wordIdx;
   logic        w_outOfRange;
   logic [31:0] w_redirectPc;
   logic [31:0] w_pcPlus4;
   logic [31:0] w_pcNext;

   // The memory is addressed directly by the fetch PC; data comes back in the
   // same cycle, so the address is simply the PC register.
   assign imem_addr        = r_pc;
   assign pc               = r_pc;
   assign IFID_pc          = r_ifidPc;
   assign IFID_instruction = r_ifidInstr;
   assign IFID_valid       = r_ifidValid;
   assign fetch_fault      = r_fetchFault;

   // Word index of the current fetch and whether it lies past the end of
   // instruction memory. The shift keeps every PC bit in the expression.
   always_comb begin
      w_wordIdx    = r_pc >> 2;
      w_outOfRange = (w_wordIdx >= IMEM_WORDS_W);
   end

   // Next-PC selection. A redirect is always word aligned by clearing the two
   // low bits of the EX target; sequential advance wraps naturally at 2^32.
   // A redirect overrides a PC stall, otherwise PCWrite gates the advance.
   always_comb begin
      w_redirectPc = branch_target & 32'hFFFF_FFFC;
      w_pcPlus4    = r_pc + 32'd4;
      w_pcNext     = r_pc;
      if (branch_taken) begin
         w_pcNext = w_redirectPc;
      end else if (PCWrite) begin
         w_pcNext = w_pcPlus4;
      end
   end

   // Fetch PC register. Reset beats everything, including a pending redirect.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc <= RESET_PC;
      end else begin
         r_pc <= w_pcNext;
      end
   end

   // IF/ID pipeline register. A redirect squashes whatever was fetched into a
   // bubble with a zero PC. Otherwise IFIDWrite decides whether the register
   // loads; an out-of-range fetch still records its PC but loads a bubble so
   // the decoder never sees garbage from beyond the memory.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ifidPc    <= 32'h0000_0000;
         r_ifidInstr <= NOP_INSTR;
         r_ifidValid <= 1'b0;
      end else if (branch_taken) begin
         r_ifidPc    <= 32'h0000_0000;
         r_ifidInstr <= NOP_INSTR;
         r_ifidValid <= 1'b0;
      end else if (IFIDWrite) begin
         r_ifidPc <= r_pc;
         if (w_outOfRange) begin
            r_ifidInstr <= NOP_INSTR;
            r_ifidValid <= 1'b0;
         end else begin
            r_ifidInstr <= imem_rdata;
            r_ifidValid <= 1'b1;
         end
      end
   end

   // Sticky fault flag. It is raised only when an out-of-range fetch is
   // actually captured into IF/ID (not on a redirect edge) and is cleared by
   // reset alone. It deliberately has no effect on PC advance.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetchFault <= 1'b0;
      end else if (!branch_taken && IFIDWrite && w_outOfRange) begin
         r_fetchFault <= 1'b1;
      end
   end

`ifdef STALL_CNT_EN
   logic [31:0] r_stallCycles;
   logic [15:0] r_flushCount;

   assign stall_cycles = r_stallCycles;
   assign flush_count  = r_flushCount;

   // Performance counters. A stall edge is one where the PC is held and no
   // redirect is in progress; a flush edge is any redirect edge. Both counters
   // stick at their maximum rather than wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stallCycles <= 32'h0000_0000;
         r_flushCount  <= 16'h0000;
      end else begin
         if (!PCWrite && !branch_taken && (r_stallCycles != 32'hFFFF_FFFF)) begin
            r_stallCycles <= r_stallCycles + 32'd1;
         end
         if (branch_taken && (r_flushCount != 16'hFFFF)) begin
            r_flushCount <= r_flushCount + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// ============================================================================
// tb_fetch_stage
// ----------------------------------------------------------------------------
// Two fetch_stage instances share the control inputs:
//    instance 0: RESET_PC = 0,           IMEM_WORDS = 4
//    instance 1: RESET_PC = 0xFFFF_FFFC, IMEM_WORDS = 256
// Each has its own memory model. A behavioural model of the fetch stage is
// advanced every rising edge and compared against both instances on every
// falling edge. A directed prologue pins the model with literal values, then
// a randomized phase exercises stalls, redirects, faults and resets.
// ============================================================================
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk;
   logic rst;
   logic PCWrite;
   logic IFIDWrite;
   logic branch_taken;
   logic [31:0] branch_target;

   logic [31:0] rdata [2];
   logic [31:0] dAddr [2];
   logic [31:0] dPc [2];
   logic [31:0] dIfPc [2];
   logic [31:0] dIfIns [2];
   logic        dIfVal [2];
   logic        dFault [2];
`ifdef STALL_CNT_EN
   logic [31:0] dStall [2];
   logic [15:0] dFlush [2];
`endif

   // Behavioural model state, one copy per instance.
   logic [31:0] mPc [2];
   logic [31:0] mIfPc [2];
   logic [31:0] mIfIns [2];
   logic        mIfVal [2];
   logic        mFault [2];
   longint      mStall [2];
   longint      mFlush [2];

   int compared;
   int mismatched;

   // Instruction memory contents: a recognisable pattern distinct from the PC.
   function automatic logic [31:0] memData(input logic [31:0] a);
      return a ^ 32'hDEAD_0000;
   endfunction

   function automatic logic [31:0] resetPcOf(input int k);
      return (k == 0) ? 32'h0000_0000 : 32'hFFFF_FFFC;
   endfunction

   function automatic longint wordsOf(input int k);
      return (k == 0) ? 64'd4 : 64'd256;
   endfunction

   assign rdata[0] = memData(dAddr[0]);
   assign rdata[1] = memData(dAddr[1]);

   fetch_stage #(.RESET_PC(32'h0000_0000), .IMEM_WORDS(4), .NOP_INSTR(NOP)) dut0 (
      .clk              (clk),
      .rst              (rst),
      .PCWrite          (PCWrite),
      .IFIDWrite        (IFIDWrite),
      .branch_taken     (branch_taken),
      .branch_target    (branch_target),
      .imem_rdata       (rdata[0]),
      .imem_addr        (dAddr[0]),
      .pc               (dPc[0]),
      .IFID_pc          (dIfPc[0]),
      .IFID_instruction (dIfIns[0]),
      .IFID_valid       (dIfVal[0]),
      .fetch_fault      (dFault[0])
`ifdef STALL_CNT_EN
      ,
      .stall_cycles     (dStall[0]),
      .flush_count      (dFlush[0])
`endif
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .IMEM_WORDS(256), .NOP_INSTR(NOP)) dut1 (
      .clk              (clk),
      .rst              (rst),
      .PCWrite          (PCWrite),
      .IFIDWrite        (IFIDWrite),
      .branch_taken     (branch_taken),
      .branch_target    (branch_target),
      .imem_rdata       (rdata[1]),
      .imem_addr        (dAddr[1]),
      .pc               (dPc[1]),
      .IFID_pc          (dIfPc[1]),
      .IFID_instruction (dIfIns[1]),
      .IFID_valid       (dIfVal[1]),
      .fetch_fault      (dFault[1])
`ifdef STALL_CNT_EN
      ,
      .stall_cycles     (dStall[1]),
      .flush_count      (dFlush[1])
`endif
   );

   // Free-running clock, 10 time-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Advance the model by one rising edge using the currently driven inputs.
   task automatic modelStep();
      for (int k = 0; k < 2; k++) begin
         logic [31:0] oldPc;
         oldPc = mPc[k];
         if (rst) begin
            mPc[k]    = resetPcOf(k);
            mIfPc[k]  = 32'h0;
            mIfIns[k] = NOP;
            mIfVal[k] = 1'b0;
            mFault[k] = 1'b0;
            mStall[k] = 0;
            mFlush[k] = 0;
         end else if (branch_taken) begin
            mPc[k]    = {branch_target[31:2], 2'b00};
            mIfPc[k]  = 32'h0;
            mIfIns[k] = NOP;
            mIfVal[k] = 1'b0;
            if (mFlush[k] < 65535) mFlush[k]++;
         end else begin
            if (PCWrite) mPc[k] = oldPc + 32'd4;
            else if (mStall[k] < 64'hFFFF_FFFF) mStall[k]++;
            if (IFIDWrite) begin
               mIfPc[k] = oldPc;
               if (longint'(oldPc / 4) < wordsOf(k)) begin
                  mIfIns[k] = memData(oldPc);
                  mIfVal[k] = 1'b1;
               end else begin
                  mIfIns[k] = NOP;
                  mIfVal[k] = 1'b0;
                  mFault[k] = 1'b1;
               end
            end
         end
      end
   endtask

   // Compare every visible output of both instances against the model.
   task automatic checkOutput(input string tag);
      for (int k = 0; k < 2; k++) begin
         cmp($sformatf("%s.u%0d.pc", tag, k), dPc[k], mPc[k]);
         cmp($sformatf("%s.u%0d.imem_addr", tag, k), dAddr[k], mPc[k]);
         cmp($sformatf("%s.u%0d.IFID_pc", tag, k), dIfPc[k], mIfPc[k]);
         cmp($sformatf("%s.u%0d.IFID_instruction", tag, k), dIfIns[k], mIfIns[k]);
         cmp($sformatf("%s.u%0d.IFID_valid", tag, k), {31'b0, dIfVal[k]}, {31'b0, mIfVal[k]});
         cmp($sformatf("%s.u%0d.fetch_fault", tag, k), {31'b0, dFault[k]}, {31'b0, mFault[k]});
`ifdef STALL_CNT_EN
         cmp($sformatf("%s.u%0d.stall_cycles", tag, k), dStall[k], mStall[k][31:0]);
         cmp($sformatf("%s.u%0d.flush_count", tag, k), {16'b0, dFlush[k]}, {16'b0, mFlush[k][15:0]});
`endif
      end
   endtask

   // Drive one cycle of inputs, take the edge, then check on the falling edge.
   task automatic applyStimulus(input logic r, input logic pw, input logic iw,
                                input logic bt, input logic [31:0] tgt, input string tag);
      rst           = r;
      PCWrite       = pw;
      IFIDWrite     = iw;
      branch_taken  = bt;
      branch_target = tgt;
      @(posedge clk);
      modelStep();
      @(negedge clk);
      checkOutput(tag);
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      for (int k = 0; k < 2; k++) begin
         mPc[k] = 32'h0; mIfPc[k] = 32'h0; mIfIns[k] = NOP;
         mIfVal[k] = 1'b0; mFault[k] = 1'b0; mStall[k] = 0; mFlush[k] = 0;
      end

      // Reset state, pinned with literals.
      applyStimulus(1, 1, 1, 0, 32'h0, "reset");
      cmp("lit.reset.pc0", dPc[0], 32'h0000_0000);
      cmp("lit.reset.pc1", dPc[1], 32'hFFFF_FFFC);
      cmp("lit.reset.ifins0", dIfIns[0], 32'h0000_0013);
      cmp("lit.reset.ifval0", {31'b0, dIfVal[0]}, 32'd0);

      // Sequential fetch: instance 1 wraps to 0 and faults on 0xFFFFFFFC.
      applyStimulus(0, 1, 1, 0, 32'h0, "seq1");
      cmp("lit.seq1.pc0", dPc[0], 32'h0000_0004);
      cmp("lit.seq1.ifins0", dIfIns[0], 32'hDEAD_0000);
      cmp("lit.seq1.pc1_wrap", dPc[1], 32'h0000_0000);
      cmp("lit.seq1.fault1", {31'b0, dFault[1]}, 32'd1);
      applyStimulus(0, 1, 1, 0, 32'h0, "seq2");
      cmp("lit.seq2.pc0", dPc[0], 32'h0000_0008);

      // Two-edge stall at pc=8, then release.
      applyStimulus(0, 0, 0, 0, 32'h0, "stall1");
      applyStimulus(0, 0, 0, 0, 32'h0, "stall2");
      cmp("lit.stall2.pc0", dPc[0], 32'h0000_0008);
      cmp("lit.stall2.ifins0", dIfIns[0], 32'hDEAD_0004);
      applyStimulus(0, 1, 1, 0, 32'h0, "release");
      cmp("lit.release.ifpc0", dIfPc[0], 32'h0000_0008);
      cmp("lit.release.ifins0", dIfIns[0], 32'hDEAD_0008);
      applyStimulus(0, 1, 1, 0, 32'h0, "seq3");
      cmp("lit.seq3.pc0", dPc[0], 32'h0000_0010);

      // Redirect at pc=0x10 with PCWrite low; target low bits are dropped.
      applyStimulus(0, 0, 1, 1, 32'h0000_0042, "branch");
      cmp("lit.branch.pc0", dPc[0], 32'h0000_0040);
      cmp("lit.branch.ifins0", dIfIns[0], 32'h0000_0013);
      cmp("lit.branch.ifval0", {31'b0, dIfVal[0]}, 32'd0);
      cmp("lit.branch.fault0", {31'b0, dFault[0]}, 32'd0);
      applyStimulus(0, 1, 1, 0, 32'h0, "afterbr");
      cmp("lit.afterbr.ifpc0", dIfPc[0], 32'h0000_0040);
      cmp("lit.afterbr.fault0", {31'b0, dFault[0]}, 32'd1);
      applyStimulus(0, 1, 1, 1, 32'h0000_0000, "brback");
      applyStimulus(0, 1, 1, 0, 32'h0, "inrange");
      cmp("lit.inrange.ifval0", {31'b0, dIfVal[0]}, 32'd1);
      cmp("lit.inrange.fault0_sticky", {31'b0, dFault[0]}, 32'd1);

      // Reset coinciding with a redirect: reset wins.
      applyStimulus(1, 1, 1, 1, 32'h0000_0080, "rstbr");
      cmp("lit.rstbr.pc0", dPc[0], 32'h0000_0000);
      cmp("lit.rstbr.pc1", dPc[1], 32'hFFFF_FFFC);
      cmp("lit.rstbr.fault0", {31'b0, dFault[0]}, 32'd0);

`ifdef STALL_CNT_EN
      // Three stall edges plus one redirect edge.
      applyStimulus(0, 0, 0, 0, 32'h0, "cnt1");
      applyStimulus(0, 0, 1, 0, 32'h0, "cnt2");
      applyStimulus(0, 0, 0, 0, 32'h0, "cnt3");
      applyStimulus(0, 0, 0, 1, 32'h0000_0008, "cnt4");
      cmp("lit.cnt.stall0", dStall[0], 32'd3);
      cmp("lit.cnt.flush0", {16'b0, dFlush[0]}, 32'd1);
`endif

      // Randomized phase.
      for (int i = 0; i < 3000; i++) begin
         logic r, pw, iw, bt;
         logic [31:0] tgt;
         r  = ($urandom_range(0, 63) == 0);
         bt = ($urandom_range(0, 7) == 0);
         pw = ($urandom_range(0, 3) != 0);
         iw = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 3))
            0:       tgt = $urandom;
            1:       tgt = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            default: tgt = $urandom & 32'h0000_03FF;
         endcase
         applyStimulus(r, pw, iw, bt, tgt, $sformatf("rand%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
